// File: rtl/alu_pkg.sv
// Shared ALU word definitions used by the subtract-path inverter and its neighbours.
package alu_pkg;

   localparam int WORD_W = 64;

   typedef logic signed [WORD_W-1:0] word_t;

endpackage

// File: rtl/not_1.sv
// Single-bit inverter cell; the word inverter is assembled from these.
module not_1 (
   input  logic x,
   output logic y
);

   assign y = ~x;

endmodule

// File: rtl/not64_unit.sv
// Word inverter supplying ~b for the ALU subtract path, with a zero-latency
// combinational output and a single-stage valid/ready registered output.
module not64_unit
   import alu_pkg::*;
#(
   parameter int N = WORD_W
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic signed [N-1:0] a,
   input  logic                in_valid,
   output logic                in_ready,
   output logic signed [N-1:0] out_comb,
   output logic signed [N-1:0] out,
   output logic                out_valid,
   input  logic                out_ready
);

   logic signed [N-1:0] w_inv;
   logic                w_in_xfer;
   logic                w_out_xfer;
   logic signed [N-1:0] r_out;
   logic                r_valid;

   // One inverter cell per bit feeds both the combinational output and the register.
   for (genvar i = 0; i < N; i++) begin : g_inv
      not_1 u_not (
         .x (a[i]),
         .y (w_inv[i])
      );
   end

   assign out_comb   = w_inv;
   assign in_ready   = ~r_valid | out_ready;
   assign w_in_xfer  = in_valid & in_ready;
   assign w_out_xfer = r_valid & out_ready;

   // Stage boundary: capture ~a; a new capture wins over a simultaneous drain.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_out   <= '0;
         r_valid <= 1'b0;
      end else if (w_in_xfer) begin
         r_out   <= w_inv;
         r_valid <= 1'b1;
      end else if (w_out_xfer) begin
         r_valid <= 1'b0;
      end
   end

   assign out       = r_out;
   assign out_valid = r_valid;

endmodule

// File: tb/tb_not64_unit.sv
// Self-checking bench for not64_unit: directed handshake cases plus a random sweep.
module tb_not64_unit;

   logic               clk;
   logic               rst_n;
   logic signed [63:0] a;
   logic               in_valid;
   logic               in_ready;
   logic signed [63:0] out_comb;
   logic signed [63:0] out;
   logic               out_valid;
   logic               out_ready;

   int checks;
   int errors;
   logic [63:0] sb_q[$];
   logic [63:0] exp_pop;

   not64_unit #(.N(64)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .a         (a),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .out_comb  (out_comb),
      .out       (out),
      .out_valid (out_valid),
      .out_ready (out_ready)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic drive(input logic [63:0] av, input logic iv, input logic ordy);
      @(negedge clk);
      a         = av;
      in_valid  = iv;
      out_ready = ordy;
      #1;
   endtask

   task automatic after_edge();
      @(posedge clk);
      #1;
   endtask

   initial begin
      checks    = 0;
      errors    = 0;
      a         = '0;
      in_valid  = 1'b0;
      out_ready = 1'b0;
      rst_n     = 1'b0;
      #1;
      chk("reset_out", out, 64'h0);
      chk("reset_out_valid", {63'b0, out_valid}, 64'h0);
      chk("reset_in_ready", {63'b0, in_ready}, 64'h1);
      #12;
      rst_n = 1'b1;

      // First capture of a = 4
      drive(64'd4, 1'b1, 1'b1);
      chk("comb_4", out_comb, 64'hFFFF_FFFF_FFFF_FFFB);
      after_edge();
      chk("reg_4", out, 64'hFFFF_FFFF_FFFF_FFFB);
      chk("valid_4", {63'b0, out_valid}, 64'h1);

      // Corner operands back-to-back
      drive(64'h0, 1'b1, 1'b1);
      after_edge();
      chk("reg_zero", out, 64'hFFFF_FFFF_FFFF_FFFF);
      chk("valid_zero", {63'b0, out_valid}, 64'h1);
      drive(64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 1'b1);
      after_edge();
      chk("reg_ones", out, 64'h0);
      chk("valid_ones", {63'b0, out_valid}, 64'h1);
      drive(64'hAAAA_AAAA_AAAA_AAAA, 1'b1, 1'b1);
      chk("comb_aa", out_comb, 64'h5555_5555_5555_5555);
      after_edge();
      chk("reg_aa", out, 64'h5555_5555_5555_5555);
      chk("valid_aa", {63'b0, out_valid}, 64'h1);

      // Back-pressure
      drive(64'd1, 1'b1, 1'b1);
      after_edge();
      chk("reg_bp_cap", out, 64'hFFFF_FFFF_FFFF_FFFE);
      for (int k = 0; k < 3; k++) begin
         drive({$urandom, $urandom}, 1'b1, 1'b0);
         chk("bp_in_ready", {63'b0, in_ready}, 64'h0);
         chk("bp_comb", out_comb, ~a);
         after_edge();
         chk("bp_out_hold", out, 64'hFFFF_FFFF_FFFF_FFFE);
         chk("bp_valid_hold", {63'b0, out_valid}, 64'h1);
      end

      // Drain
      drive(64'd9, 1'b0, 1'b1);
      after_edge();
      chk("drain_valid", {63'b0, out_valid}, 64'h0);
      chk("drain_in_ready", {63'b0, in_ready}, 64'h1);
      chk("drain_out_kept", out, 64'hFFFF_FFFF_FFFF_FFFE);

      // Async reset mid-stream
      drive(64'd7, 1'b1, 1'b0);
      after_edge();
      chk("pre_rst_valid", {63'b0, out_valid}, 64'h1);
      @(negedge clk);
      a     = 64'h1234_5678_9ABC_DEF0;
      rst_n = 1'b0;
      #1;
      chk("async_rst_out", out, 64'h0);
      chk("async_rst_valid", {63'b0, out_valid}, 64'h0);
      chk("async_rst_comb", out_comb, 64'hEDCB_A987_6543_210F);
      #1;
      rst_n    = 1'b1;
      in_valid = 1'b0;

      // Random sweep against an in-order scoreboard of accepted results
      sb_q.delete();
      for (int n = 0; n < 1000; n++) begin
         drive({$urandom, $urandom}, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 3) != 0));
         chk("rnd_comb", out_comb, ~a);
         chk("rnd_valid", {63'b0, out_valid}, {63'b0, (sb_q.size() != 0)});
         chk("rnd_in_ready", {63'b0, in_ready}, {63'b0, (sb_q.size() == 0) | out_ready});
         if (sb_q.size() != 0) chk("rnd_out_hold", out, sb_q[0]);
         if ((sb_q.size() != 0) && out_ready) begin
            exp_pop = sb_q.pop_front();
            chk("rnd_out", out, exp_pop);
         end
         if (in_valid && ((sb_q.size() == 0) || out_ready)) sb_q.push_back(~a);
         @(posedge clk);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/not64_unit.md
Name: not64_unit

Overview:
- 64-bit bitwise inverter for the ALU subtract path; SUB forms a + ~b + 1, and this block supplies ~b.
- Provides two outputs:
  - a combinational result, out_comb = ~a, for the same-cycle ALU datapath;
  - a registered copy with a valid/ready handshake, for pipelined use.
- Operands are treated as signed, but the operation is purely bitwise, so sign has no effect on the result.

Parameters:
- N, 64, operand/result width in bits. Must be ≥ 1. All widths below scale with N.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- a  input  N  operand (signed)
- in_valid  input  1  a is presented for capture
- in_ready  output  1  block can accept a this cycle
- out_comb  output  N  combinational ~a, zero latency
- out  output  N  registered result (signed)
- out_valid  output  1  out holds a valid result
- out_ready  input  1  downstream accepts out this cycle

Behaviour:
- Combinational path:
  - out_comb[i] = ~a[i] for every i, at all times, independent of clk, rst_n and handshake.
  - Example: a = 4 gives out_comb = 0xFFFF_FFFF_FFFF_FFFB.
- Reset (rst_n low, asynchronous, takes effect immediately with no clock edge):
  - out = 0, out_valid = 0.
  - in_ready follows its normal equation, which gives 1 with out_valid = 0.
  - On release, the first capture can happen on the first rising clk edge where in_valid = 1.
- Ready equation: in_ready = ~out_valid | out_ready (single-stage pipeline register, no skid buffer).
- Input transfer: a transfer happens on a rising edge when in_valid & in_ready.
  - out <= ~a and out_valid <= 1.
  - Latency is one cycle from capture to out_valid.
- Output transfer: happens on a rising edge when out_valid & out_ready.
  - If no input transfer happens on that same edge: out_valid <= 0 and out keeps its last value.
- Simultaneous input and output transfer on one edge: the new result replaces the old; out_valid stays 1. Full throughput is one result per cycle.
- Back-pressure (out_valid = 1, out_ready = 0):
  - in_ready = 0; out and out_valid hold.
  - a may change freely; it is not sampled.
- in_valid = 0 with no output transfer: state holds.
- Reset mid-operation: a pending result is discarded; out_valid returns to 0 asynchronously.
- No overflow or carry concept:
  - ~0 = all ones;
  - ~(all ones) = 0;
  - ~(−1) = 0 and ~0 = −1 when read as signed.
- No X propagation from the handshake: out changes only on an input transfer or on reset.

Decomposition:
- Shared package (alu_pkg) holds:
  - constant WORD_W = 64;
  - typedef word_t = logic signed [WORD_W-1:0].
- The inversion is built structurally from one sub-module, not_1 (single-bit inverter: y = ~x), instantiated N times in a generate loop.
- The not_1 array drives both out_comb and the D input of the out register.
- The handshake register logic sits in the top level.

Test Plan:
- Reset then a = 4, in_valid = 1, out_ready = 1 →
  - out_comb = 0xFFFF_FFFF_FFFF_FFFB immediately;
  - out = 0xFFFF_FFFF_FFFF_FFFB with out_valid = 1 after one edge.
- Corner operands a = 0, then a = 0xFFFF_FFFF_FFFF_FFFF, then a = 0xAAAA_AAAA_AAAA_AAAA, back-to-back with out_ready = 1 →
  - outputs, one per cycle with out_valid held 1: 0xFFFF_FFFF_FFFF_FFFF, then 0, then 0x5555_5555_5555_5555.
- Back-pressure: capture a = 1, then hold out_ready = 0 for 3 cycles while a changes →
  - out stays 0xFFFF_FFFF_FFFF_FFFE;
  - in_ready = 0 throughout;
  - out_valid = 1 throughout.
- Drain: after back-pressure, out_ready = 1 with in_valid = 0 →
  - out_valid falls to 0 after one edge;
  - in_ready = 1.
- Async reset mid-stream: assert rst_n = 0 between edges while out_valid = 1 →
  - out = 0 and out_valid = 0 at once, without a clock edge;
  - out_comb still tracks ~a.
- Random sweep: 1000 random a values with random in_valid/out_ready →
  - every accepted a appears as ~a on out exactly once, in order;
  - out_comb == ~a at all times.
